// File: rtl/word_window_reg.sv
// DEPTH-word x WIDTH-bit register window with hold/shift-in/rotate/parallel-load modes,
// saturating occupancy count and a one-cycle overflow pulse (e.g. SHA-256 message schedule).
module word_window_reg #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int CNT_W = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr,
   input  logic [1:0]             mode,
   input  logic [WIDTH-1:0]       din,
   input  logic [DEPTH*WIDTH-1:0] pdata,
   output logic [DEPTH*WIDTH-1:0] Q,
   output logic [WIDTH-1:0]       newest,
   output logic [WIDTH-1:0]       oldest,
   output logic [CNT_W-1:0]       count,
   output logic                   full,
   output logic                   empty,
   output logic                   ovf
);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_SHIFT = 2'b01;
   localparam logic [1:0] MODE_ROT   = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   // Word i occupies bits [i*WIDTH +: WIDTH], matching the flattened Q layout.
   logic [DEPTH-1:0][WIDTH-1:0] win_q, win_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        ovf_q, ovf_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_FULL) ? c : c + CNT_W'(1);
   endfunction

   always_comb begin
      win_d = win_q;
      cnt_d = cnt_q;
      ovf_d = 1'b0;
      if (clr) begin
         win_d = '0;
         cnt_d = '0;
      end else begin
         case (mode)
            MODE_HOLD: ;
            MODE_SHIFT: begin
               win_d = {win_q[DEPTH-2:0], din};
               cnt_d = sat_inc(cnt_q);
               ovf_d = (cnt_q == CNT_FULL);
            end
            // Rotation spans the whole physical window, including words not yet valid.
            MODE_ROT:  win_d = {win_q[DEPTH-2:0], win_q[DEPTH-1]};
            MODE_LOAD: begin
               win_d = pdata;
               cnt_d = CNT_FULL;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         win_q <= win_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign Q      = win_q;
   assign newest = win_q[0];
   assign oldest = win_q[DEPTH-1];
   assign count  = cnt_q;
   assign full   = (cnt_q == CNT_FULL);
   assign empty  = (cnt_q == '0);
   assign ovf    = ovf_q;

endmodule
